uart_stream_ctrl: RTL

// Bus-master sequencer for the memory-mapped uart peripheral. It initialises the uart after reset,

---
 rtl/uart_stream_ctrl_if.sv | 19 +
 rtl/uart_stream_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_ctrl_if.sv
// Register-window bus between the stream controller (master) and the uart (slave).
interface uart_stream_ctrl_if;
  logic        bus_select;
  logic [3:0]  bus_wstrb;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_select, bus_wstrb, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_select, bus_wstrb, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/uart_stream_ctrl.sv
// Bus-master sequencer for the uart register window: initialises the uart,
// then drains a TX byte FIFO into TXDATA and forwards received bytes as pulses.
module uart_stream_ctrl #(
  parameter logic [31:0] BAUD_PRESC   = 32'h1B2,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          GUARD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          rx_valid,
  output logic [7:0]                    rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          init_done,
  uart_stream_ctrl_if.master            bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int GW = $clog2(GUARD_CYCLES);

  localparam logic [4:0] ADDR_CONFIG = 5'h00;
  localparam logic [4:0] ADDR_BAUD   = 5'h04;
  localparam logic [4:0] ADDR_STATUS = 5'h08;
  localparam logic [4:0] ADDR_RXDATA = 5'h0C;
  localparam logic [4:0] ADDR_TXDATA = 5'h10;

  typedef enum logic [2:0] {
    S_INIT_RST,
    S_INIT_BAUD,
    S_INIT_EN,
    S_POLL,
    S_RX_RD,
    S_RX_CLR,
    S_TX_WR,
    S_GUARD
  } state_t;

  // FSM / bus registers
  state_t          state_q, state_d;
  logic            busy_q, busy_d;      // an access has been issued and awaits bus_ready
  logic            sel_q, sel_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic            init_done_q, init_done_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            push;
  logic            pop;
  logic [7:0]      fifo_head;

  state_t          next_state;
  state_t          issue_state;
  logic            issue_now;

  // Only the low byte and the two status flags of read data matter here.
  logic            unused_rdata_hi;
  assign unused_rdata_hi = ^bus.bus_rdata[31:8];

  assign in_ready   = init_done_q && (level_q != LW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_head  = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign init_done  = init_done_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;

  assign bus.bus_select = sel_q;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_wdata  = wdata_q;
  assign bus.bus_wstrb  = wstrb_q;

  // Next-state logic: complete the access in flight, choose the next state and
  // issue its access in the same cycle so select follows ready without a gap.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    sel_d       = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    guard_d     = guard_q;
    init_done_d = init_done_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    pop         = 1'b0;
    next_state  = state_q;
    issue_state = state_q;
    issue_now   = 1'b0;

    if (state_q == S_GUARD) begin
      if (guard_q == '0) begin
        state_d     = S_POLL;
        issue_state = S_POLL;
        issue_now   = 1'b1;
      end else begin
        guard_d = guard_q - 1'b1;
      end
    end else if (!busy_q) begin
      // First access after reset.
      issue_state = state_q;
      issue_now   = 1'b1;
    end else if (!sel_q && bus.bus_ready) begin
      case (state_q)
        S_INIT_RST:  next_state = S_INIT_BAUD;
        S_INIT_BAUD: next_state = S_INIT_EN;
        S_INIT_EN: begin
          next_state  = S_POLL;
          init_done_d = 1'b1;
        end
        S_POLL: begin
          if (bus.bus_rdata[0])
            next_state = S_RX_RD;
          else if (!bus.bus_rdata[1] && (level_q != '0))
            next_state = S_TX_WR;
          else
            next_state = S_POLL;
        end
        S_RX_RD: begin
          rx_data_d  = bus.bus_rdata[7:0];
          rx_valid_d = 1'b1;
          next_state = S_RX_CLR;
        end
        S_RX_CLR:    next_state = S_POLL;
        S_TX_WR: begin
          pop        = 1'b1;
          next_state = S_GUARD;
        end
        default:     next_state = S_INIT_RST;
      endcase
      state_d = next_state;
      if (next_state == S_GUARD) begin
        busy_d  = 1'b0;
        guard_d = GW'(GUARD_CYCLES - 1);
      end else begin
        issue_state = next_state;
        issue_now   = 1'b1;
      end
    end

    if (issue_now) begin
      sel_d  = 1'b1;
      busy_d = 1'b1;
      case (issue_state)
        S_INIT_RST:  begin addr_d = ADDR_CONFIG; wdata_d = 32'h1;             wstrb_d = 4'hF; end
        S_INIT_BAUD: begin addr_d = ADDR_BAUD;   wdata_d = BAUD_PRESC;        wstrb_d = 4'hF; end
        S_INIT_EN:   begin addr_d = ADDR_CONFIG; wdata_d = 32'h2;             wstrb_d = 4'hF; end
        S_POLL:      begin addr_d = ADDR_STATUS; wdata_d = 32'h0;             wstrb_d = 4'h0; end
        S_RX_RD:     begin addr_d = ADDR_RXDATA; wdata_d = 32'h0;             wstrb_d = 4'h0; end
        S_RX_CLR:    begin addr_d = ADDR_STATUS; wdata_d = 32'h0;             wstrb_d = 4'hF; end
        S_TX_WR:     begin addr_d = ADDR_TXDATA; wdata_d = {24'd0, fifo_head}; wstrb_d = 4'hF; end
        default:     begin sel_d = 1'b0; busy_d = busy_q; end
      endcase
    end
  end

  // FSM and bus output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT_RST;
      busy_q      <= 1'b0;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      guard_q     <= '0;
      init_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      guard_q     <= guard_d;
      init_done_q <= init_done_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
    end
  end

  // FIFO pointers and fill level; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
